// File: rtl/alu_cmd_driver_if.sv
// Purpose: command, ALU-operand and response signals of alu_cmd_driver.
// Latency: none; this file only declares wires.
// Backpressure: cmd_valid/cmd_ready and rsp_valid/rsp_ready handshakes.
interface alu_cmd_driver_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [1:0] cmd_s;

    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [1:0] alu_s;
    logic [7:0] alu_f;
    logic       alu_ovf;

    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_f;
    logic       rsp_ovf;
    logic [1:0] rsp_s;

    // Requester side: issues commands, sinks responses, and hosts the ALU.
    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_s,
        input  cmd_ready,
        input  alu_a, alu_b, alu_s,
        output alu_f, alu_ovf,
        input  rsp_valid, rsp_f, rsp_ovf, rsp_s,
        output rsp_ready
    );

    // Driver side: accepts commands, drives the ALU, returns responses.
    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_s,
        output cmd_ready,
        output alu_a, alu_b, alu_s,
        input  alu_f, alu_ovf,
        output rsp_valid, rsp_f, rsp_ovf, rsp_s,
        input  rsp_ready
    );
endinterface

// File: rtl/alu_cmd_driver.sv
// Purpose: registers a command onto an external combinational ALU, samples its result.
// Latency: response valid SETTLE_CYC cycles after command accept; one command in flight.
// Backpressure: cmd_ready only in IDLE; the response is held until rsp_ready.
module alu_cmd_driver #(
    parameter int unsigned SETTLE_CYC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_cmd_driver_if.slave   bus,
    output logic              ovf_sticky,
    input  logic              sticky_clr,
    output logic [7:0]        op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] settle_cnt;
    logic       accept;
    logic       capture;
    logic       rsp_hs;
    logic       cap_ovf;

    // Ready is gated by rst_n so it drops the instant reset asserts.
    assign bus.cmd_ready = rst_n && (state == IDLE);

    assign accept  = bus.cmd_valid && (state == IDLE);
    assign capture = (state == WAIT) && (settle_cnt == 4'd0);
    assign rsp_hs  = (state == RESP) && bus.rsp_ready;
    // Overflow is only meaningful for the add operation.
    assign cap_ovf = (bus.alu_s == 2'b00) ? bus.alu_ovf : 1'b0;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)  state_nxt = WAIT;
            WAIT:    if (capture) state_nxt = RESP;
            RESP:    if (rsp_hs)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand registers and settle counter; operands only change on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.alu_a  <= 8'h00;
            bus.alu_b  <= 8'h00;
            bus.alu_s  <= 2'b00;
            settle_cnt <= 4'd0;
        end else if (accept) begin
            bus.alu_a  <= bus.cmd_a;
            bus.alu_b  <= bus.cmd_b;
            bus.alu_s  <= bus.cmd_s;
            settle_cnt <= SETTLE_LOAD;
        end else if ((state == WAIT) && (settle_cnt != 4'd0)) begin
            settle_cnt <= settle_cnt - 4'd1;
        end
    end

    // Response registers; payload is kept after the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_f     <= 8'h00;
            bus.rsp_ovf   <= 1'b0;
            bus.rsp_s     <= 2'b00;
        end else if (capture) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_f     <= bus.alu_f;
            bus.rsp_ovf   <= cap_ovf;
            bus.rsp_s     <= bus.alu_s;
        end else if (rsp_hs) begin
            bus.rsp_valid <= 1'b0;
        end
    end

    // Sticky overflow: a capture with overflow beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
        end else if (capture && cap_ovf) begin
            ovf_sticky <= 1'b1;
        end else if (sticky_clr) begin
            ovf_sticky <= 1'b0;
        end
    end

    // Completed-response counter, wraps silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= 8'h00;
        end else if (rsp_hs) begin
            op_count <= op_count + 8'h01;
        end
    end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Purpose: random and directed checks of alu_cmd_driver at SETTLE_CYC 1 and 4.
// Latency: measured per command against the expected settle count.
// Backpressure: rsp_ready held low for random stretches; cmd_valid pulsed while busy.
module tb_alu_cmd_driver;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Shared stimulus, steered to one DUT by sel (0: SETTLE_CYC=1, 1: SETTLE_CYC=4).
    logic       sel = 1'b0;
    logic       c_valid = 1'b0;
    logic [7:0] c_a = 8'h00;
    logic [7:0] c_b = 8'h00;
    logic [1:0] c_s = 2'b00;
    logic       r_ready = 1'b0;
    logic       s_clr = 1'b0;

    alu_cmd_driver_if if1 ();
    alu_cmd_driver_if if4 ();

    logic       sticky1, sticky4, clr1, clr4;
    logic [7:0] cnt1, cnt4;

    // External ALU: ovf reports signed add overflow whatever the opcode.
    function automatic logic [8:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [1:0] s);
        logic [7:0] sum;
        logic [7:0] f;
        sum = a + b;
        case (s)
            2'b00:   f = sum;
            2'b01:   f = ~b;
            2'b10:   f = a & b;
            default: f = a | b;
        endcase
        return {(a[7] == b[7]) && (sum[7] != a[7]), f};
    endfunction

    assign if1.cmd_valid = c_valid & ~sel;
    assign if4.cmd_valid = c_valid & sel;
    assign if1.cmd_a = c_a;
    assign if1.cmd_b = c_b;
    assign if1.cmd_s = c_s;
    assign if4.cmd_a = c_a;
    assign if4.cmd_b = c_b;
    assign if4.cmd_s = c_s;
    assign if1.rsp_ready = r_ready & ~sel;
    assign if4.rsp_ready = r_ready & sel;
    assign clr1 = s_clr & ~sel;
    assign clr4 = s_clr & sel;
    assign {if1.alu_ovf, if1.alu_f} = alu_model(if1.alu_a, if1.alu_b, if1.alu_s);
    assign {if4.alu_ovf, if4.alu_f} = alu_model(if4.alu_a, if4.alu_b, if4.alu_s);

    alu_cmd_driver #(.SETTLE_CYC(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave),
        .ovf_sticky(sticky1), .sticky_clr(clr1), .op_count(cnt1)
    );
    alu_cmd_driver #(.SETTLE_CYC(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(if4.slave),
        .ovf_sticky(sticky4), .sticky_clr(clr4), .op_count(cnt4)
    );

    // Observed outputs of the selected DUT.
    logic       o_cmd_ready, o_rsp_valid, o_rsp_ovf, o_sticky;
    logic [7:0] o_rsp_f, o_alu_a, o_alu_b, o_cnt;
    logic [1:0] o_rsp_s, o_alu_s;
    assign o_cmd_ready = sel ? if4.cmd_ready : if1.cmd_ready;
    assign o_rsp_valid = sel ? if4.rsp_valid : if1.rsp_valid;
    assign o_rsp_ovf   = sel ? if4.rsp_ovf   : if1.rsp_ovf;
    assign o_rsp_f     = sel ? if4.rsp_f     : if1.rsp_f;
    assign o_rsp_s     = sel ? if4.rsp_s     : if1.rsp_s;
    assign o_alu_a     = sel ? if4.alu_a     : if1.alu_a;
    assign o_alu_b     = sel ? if4.alu_b     : if1.alu_b;
    assign o_alu_s     = sel ? if4.alu_s     : if1.alu_s;
    assign o_sticky    = sel ? sticky4       : sticky1;
    assign o_cnt       = sel ? cnt4          : cnt1;

    // Reference model state.
    int   exp_cnt = 0;
    logic exp_sticky = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Spec-level result: integer arithmetic for add, bitwise rules otherwise.
    function automatic logic [8:0] ref_rsp(input logic [7:0] a, input logic [7:0] b,
                                           input logic [1:0] s);
        int sa, sb, sum;
        logic [7:0] f;
        logic       o;
        sa = int'($signed(a));
        sb = int'($signed(b));
        sum = sa + sb;
        o = 1'b0;
        case (s)
            2'b00: begin
                f = 8'((sum + 256) % 256);
                o = (sum > 127) || (sum < -128);
            end
            2'b01:   f = ~b;
            2'b10:   f = a & b;
            default: f = a | b;
        endcase
        return {o, f};
    endfunction

    task automatic chk_reset_vals(input string who);
        chk({who, "_rst_cmd_ready"}, 32'(o_cmd_ready), 32'd0);
        chk({who, "_rst_rsp_valid"}, 32'(o_rsp_valid), 32'd0);
        chk({who, "_rst_alu_a"},     32'(o_alu_a), 32'd0);
        chk({who, "_rst_alu_b"},     32'(o_alu_b), 32'd0);
        chk({who, "_rst_alu_s"},     32'(o_alu_s), 32'd0);
        chk({who, "_rst_rsp_f"},     32'(o_rsp_f), 32'd0);
        chk({who, "_rst_rsp_s"},     32'(o_rsp_s), 32'd0);
        chk({who, "_rst_rsp_ovf"},   32'(o_rsp_ovf), 32'd0);
        chk({who, "_rst_sticky"},    32'(o_sticky), 32'd0);
        chk({who, "_rst_op_count"},  32'(o_cnt), 32'd0);
    endtask

    // One full command on the selected DUT, called at a negedge with the DUT idle.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] s,
                          input int hold, input logic clr);
        logic [8:0] r;
        int n;
        r = ref_rsp(a, b, s);
        chk("cmd_ready_idle", 32'(o_cmd_ready), 32'd1);
        c_valid = 1'b1; c_a = a; c_b = b; c_s = s; s_clr = clr; r_ready = 1'($urandom);
        @(negedge clk);
        n = 0;
        while (!o_rsp_valid && n < 40) begin
            chk("wait_alu_a", 32'(o_alu_a), 32'(a));
            chk("wait_alu_b", 32'(o_alu_b), 32'(b));
            chk("wait_alu_s", 32'(o_alu_s), 32'(s));
            chk("wait_cmd_ready", 32'(o_cmd_ready), 32'd0);
            c_valid = 1'($urandom); c_a = 8'($urandom); c_b = 8'($urandom);
            c_s = 2'($urandom); r_ready = 1'($urandom);
            @(negedge clk);
            n++;
        end
        s_clr = 1'b0;
        exp_sticky = clr ? r[8] : (exp_sticky | r[8]);
        chk("latency", 32'(n), sel ? 32'd4 : 32'd1);
        chk("rsp_f", 32'(o_rsp_f), 32'(r[7:0]));
        chk("rsp_ovf", 32'(o_rsp_ovf), 32'(r[8]));
        chk("rsp_s", 32'(o_rsp_s), 32'(s));
        chk("sticky", 32'(o_sticky), 32'(exp_sticky));
        for (int i = 0; i < hold; i++) begin
            r_ready = 1'b0; c_valid = 1'($urandom); c_a = 8'($urandom);
            @(negedge clk);
            chk("hold_rsp_valid", 32'(o_rsp_valid), 32'd1);
            chk("hold_rsp_f", 32'(o_rsp_f), 32'(r[7:0]));
            chk("hold_cmd_ready", 32'(o_cmd_ready), 32'd0);
            chk("hold_alu_a", 32'(o_alu_a), 32'(a));
        end
        r_ready = 1'b1; c_valid = 1'b0;
        @(negedge clk);
        r_ready = 1'b0;
        exp_cnt = (exp_cnt + 1) % 256;
        chk("post_rsp_valid", 32'(o_rsp_valid), 32'd0);
        chk("post_op_count", 32'(o_cnt), 32'(exp_cnt));
        chk("post_rsp_f", 32'(o_rsp_f), 32'(r[7:0]));
        chk("post_alu_b", 32'(o_alu_b), 32'(b));
        chk("post_cmd_ready", 32'(o_cmd_ready), 32'd1);
        chk("post_sticky", 32'(o_sticky), 32'(exp_sticky));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        sel = 1'b0; #1; chk_reset_vals("d1");
        sel = 1'b1; #1; chk_reset_vals("d4");
        sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_cmd_ready", 32'(o_cmd_ready), 32'd1);

        // Directed: add, add with overflow, not-b, backpressured and, or.
        run_op(8'h07, 8'h64, 2'b00, 0, 1'b0);
        run_op(8'h50, 8'h5A, 2'b00, 0, 1'b0);
        run_op(8'h0F, 8'h5A, 2'b01, 0, 1'b0);
        run_op(8'h8F, 8'h95, 2'b10, 5, 1'b0);
        run_op(8'h8F, 8'h95, 2'b11, 0, 1'b0);
        // Set and clear on the same capture edge, then a clear with no set.
        run_op(8'h7F, 8'h01, 2'b00, 0, 1'b1);
        run_op(8'h01, 8'h02, 2'b00, 0, 1'b1);

        // Random traffic on the fast instance.
        for (int i = 0; i < 40; i++)
            run_op(8'($urandom), 8'($urandom), 2'($urandom), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 4) == 0));

        // Slow instance: latency with busy-time cmd_valid pulses.
        sel = 1'b1;
        exp_cnt = 0; exp_sticky = 1'b0;
        @(negedge clk);
        run_op(8'h50, 8'h5A, 2'b00, 2, 1'b0);
        for (int i = 0; i < 6; i++)
            run_op(8'($urandom), 8'($urandom), 2'($urandom), int'($urandom_range(0, 2)), 1'b0);

        // Reset in the middle of WAIT.
        c_valid = 1'b1; c_a = 8'h12; c_b = 8'h34; c_s = 2'b11;
        @(negedge clk);
        c_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("wait_rst");
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0; exp_sticky = 1'b0;
        r_ready = 1'b1;
        @(negedge clk);
        chk("rst_release_cmd_ready", 32'(o_cmd_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("aborted_no_rsp", 32'(o_rsp_valid), 32'd0);
        end
        r_ready = 1'b0;
        chk("aborted_op_count", 32'(o_cnt), 32'd0);

        // Counter wrap: 256 handshakes on the fast instance after reset.
        sel = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 256; i++)
            run_op(8'($urandom), 8'($urandom), 2'($urandom), 0, 1'b0);
        chk("wrap_op_count", 32'(o_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
